vector_exec_unit: RTL and testbench

//  Element-serial vector ALU stage that sits between the vector register file read ports and its write port.

---
 rtl/vec_pkg.sv | 23 ++
 rtl/vec_lane_alu.sv | 29 ++
 rtl/vector_exec_unit.sv | 147 ++++++++++++++
 tb/tb_vector_exec_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and sizes for the element-serial vector execution stage.
package vec_pkg;

  localparam int unsigned VLANES = 5;
  localparam int unsigned VXLEN  = 32;
  localparam int unsigned VCNTW  = 3;

  typedef enum logic [2:0] {
    VOP_ADD = 3'b000,
    VOP_SUB = 3'b001,
    VOP_MUL = 3'b010,
    VOP_AND = 3'b011,
    VOP_ORR = 3'b100,
    VOP_EOR = 3'b101
  } vop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } vstate_t;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU, time-shared across vector lanes.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int unsigned XLEN = VXLEN
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result_c,
  output logic            illegal_c
);

  // Products keep only the low XLEN bits.
  always_comb begin
    result_c  = '0;
    illegal_c = 1'b0;
    case (op)
      VOP_ADD: result_c = a + b;
      VOP_SUB: result_c = a - b;
      VOP_MUL: result_c = a * b;
      VOP_AND: result_c = a & b;
      VOP_ORR: result_c = a | b;
      VOP_EOR: result_c = a ^ b;
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/vector_exec_unit.sv
// Element-serial vector ALU stage: latch operands, compute one lane per cycle,
// then issue a single-cycle register-file write-back.
module vector_exec_unit
  import vec_pkg::*;
#(
  parameter int unsigned LANES = VLANES,
  parameter int unsigned XLEN  = VXLEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [VCNTW-1:0]      vector_size,
  input  logic [3:0]            wa_in,
  input  logic [LANES*XLEN-1:0] va,
  input  logic [LANES*XLEN-1:0] vb,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  vwe,
  output logic [3:0]            wa3,
  output logic [VCNTW-1:0]      vsize_out,
  output logic [XLEN-1:0]       wd1,
  output logic [XLEN-1:0]       wd2,
  output logic [XLEN-1:0]       wd3,
  output logic [XLEN-1:0]       wd4,
  output logic [XLEN-1:0]       wd5
);

  vstate_t          state_q, state_d;
  logic [VCNTW-1:0] k_q, k_d;
  logic [2:0]       op_q, op_d;
  logic [VCNTW-1:0] size_q, size_d;
  logic [3:0]       wa_q, wa_d;
  logic             ill_q, ill_d;
  logic [XLEN-1:0]  va_q [LANES];
  logic [XLEN-1:0]  va_d [LANES];
  logic [XLEN-1:0]  vb_q [LANES];
  logic [XLEN-1:0]  vb_d [LANES];
  logic [XLEN-1:0]  wd_q [LANES];
  logic [XLEN-1:0]  wd_d [LANES];
  logic             busy_d, done_d, err_d, vwe_d;

  logic [VCNTW-1:0] size_clamp_c;
  logic [2:0]       alu_op_c;
  logic [XLEN-1:0]  alu_res_c;
  logic             alu_ill_c;

  assign size_clamp_c = (vector_size > VCNTW'(LANES)) ? VCNTW'(LANES) : vector_size;

  // In IDLE the ALU only serves as the legality decoder for the incoming op.
  assign alu_op_c = (state_q == IDLE) ? op : op_q;

  vec_lane_alu #(.XLEN(XLEN)) u_alu (
    .op        (alu_op_c),
    .a         (va_q[k_q]),
    .b         (vb_q[k_q]),
    .result_c  (alu_res_c),
    .illegal_c (alu_ill_c)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    size_d  = size_q;
    wa_d    = wa_q;
    ill_d   = ill_q;
    va_d    = va_q;
    vb_d    = vb_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          size_d = size_clamp_c;
          wa_d   = wa_in;
          ill_d  = alu_ill_c;
          k_d    = '0;
          for (int i = 0; i < LANES; i++) begin
            va_d[i] = va[i*XLEN +: XLEN];
            vb_d[i] = vb[i*XLEN +: XLEN];
            wd_d[i] = '0;
          end
          state_d = ((size_clamp_c != '0) && !alu_ill_c) ? EXEC : WB;
        end
      end
      EXEC: begin
        wd_d[k_q] = alu_res_c;
        if (k_q == size_q - VCNTW'(1)) begin
          k_d     = '0;
          state_d = WB;
        end else begin
          k_d = k_q + VCNTW'(1);
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == WB);
    vwe_d  = (state_q == EXEC) && (state_d == WB);
    err_d  = (state_d == WB) && ill_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_q    <= '0;
      size_q  <= '0;
      wa_q    <= '0;
      ill_q   <= 1'b0;
      va_q    <= '{default: '0};
      vb_q    <= '{default: '0};
      wd_q    <= '{default: '0};
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      vwe     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      size_q  <= size_d;
      wa_q    <= wa_d;
      ill_q   <= ill_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      wd_q    <= wd_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      vwe     <= vwe_d;
    end
  end

  assign wa3       = wa_q;
  assign vsize_out = size_q;
  assign wd1       = wd_q[0];
  assign wd2       = wd_q[1];
  assign wd3       = wd_q[2];
  assign wd4       = wd_q[3];
  assign wd5       = wd_q[4];

endmodule

// File: tb/tb_vector_exec_unit.sv
// Bench for vector_exec_unit: cycle-level reference model plus directed vectors.
module tb_vector_exec_unit;
  import vec_pkg::*;

  localparam int unsigned L = VLANES;
  localparam int unsigned X = VXLEN;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [2:0]     op;
  logic [2:0]     vector_size;
  logic [3:0]     wa_in;
  logic [L*X-1:0] va, vb;
  logic           busy, done, err, vwe;
  logic [3:0]     wa3;
  logic [2:0]     vsize_out;
  logic [X-1:0]   wd1, wd2, wd3, wd4, wd5;
  logic [X-1:0]   wd_a [L];

  int total = 0;
  int bad   = 0;

  vector_exec_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .vector_size(vector_size), .wa_in(wa_in), .va(va), .vb(vb),
    .busy(busy), .done(done), .err(err), .vwe(vwe), .wa3(wa3),
    .vsize_out(vsize_out), .wd1(wd1), .wd2(wd2), .wd3(wd3), .wd4(wd4), .wd5(wd5)
  );

  assign wd_a[0] = wd1;
  assign wd_a[1] = wd2;
  assign wd_a[2] = wd3;
  assign wd_a[3] = wd4;
  assign wd_a[4] = wd5;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_lane(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return p[31:0];
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: remaining busy cycles and the final write-back image.
  int           m_left = 0;
  int           m_n    = 0;
  logic         m_ill  = 1'b0;
  logic [3:0]   m_wa   = '0;
  logic [31:0]  m_wd [L] = '{default: '0};

  always @(negedge clk) begin
    if (!reset_n) begin
      m_left = 0; m_n = 0; m_ill = 1'b0; m_wa = '0;
      for (int i = 0; i < L; i++) m_wd[i] = '0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_vwe",  32'(vwe),  32'd0);
      check("rst_done", 32'(done), 32'd0);
      for (int i = 0; i < L; i++) check("rst_wd", wd_a[i], 32'd0);
    end else begin
      check("m_busy", 32'(busy), 32'(m_left > 0));
      check("m_done", 32'(done), 32'(m_left == 1));
      check("m_vwe",  32'(vwe),  32'((m_left == 1) && !m_ill && (m_n > 0)));
      check("m_err",  32'(err),  32'((m_left == 1) && m_ill));
      if (m_left <= 1) begin
        for (int i = 0; i < L; i++) check("m_wd", wd_a[i], m_wd[i]);
        check("m_wa3",   32'(wa3),       32'(m_wa));
        check("m_vsize", 32'(vsize_out), 32'(m_n));
      end
      if (m_left > 0) begin
        m_left--;
      end else if (start) begin
        m_n   = (vector_size > 3'd5) ? 5 : int'(vector_size);
        m_ill = (op > 3'd5);
        m_wa  = wa_in;
        for (int i = 0; i < L; i++)
          m_wd[i] = (!m_ill && i < m_n) ? ref_lane(op, va[i*X +: X], vb[i*X +: X]) : 32'd0;
        m_left = (!m_ill && m_n > 0) ? m_n + 1 : 1;
      end
    end
  end

  int   lat;
  logic d_vwe, d_err;

  task automatic run_op(input logic [2:0] o, input logic [2:0] sz, input logic [3:0] w);
    @(posedge clk); #1;
    op = o; vector_size = sz; wa_in = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    d_vwe = vwe;
    d_err = err;
  endtask

  int nd;
  logic d3, d7;

  initial begin
    reset_n = 1'b1; start = 1'b0; op = '0; vector_size = '0; wa_in = '0; va = '0; vb = '0;
    #1 reset_n = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wa3",  32'(wa3),  32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // ADD, size 5
    va = {32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
    vb = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3};
    run_op(3'b000, 3'd5, 4'd3);
    check("add_lat", 32'(lat), 32'd6);
    check("add_wd1", wd1, 32'd5);
    check("add_wd5", wd5, 32'd9);
    check("add_vwe", 32'(d_vwe), 32'd1);
    check("add_wa3", 32'(wa3), 32'd3);
    check("add_vsize", 32'(vsize_out), 32'd5);

    // SUB, size 2; lanes beyond size must come back 0
    va = {32'd99, 32'd99, 32'd99, 32'd0, 32'd1};
    vb = {32'd11, 32'd11, 32'd11, 32'd0, 32'd2};
    run_op(3'b001, 3'd2, 4'd7);
    check("sub_lat", 32'(lat), 32'd3);
    check("sub_wd1", wd1, 32'hFFFF_FFFF);
    check("sub_wd2", wd2, 32'd0);
    check("sub_wd3", wd3, 32'd0);

    // MUL overflow then small product
    va = {128'd0, 32'h0001_0000};
    vb = {128'd0, 32'h0001_0000};
    run_op(3'b010, 3'd1, 4'd1);
    check("mul_ovf", wd1, 32'd0);
    check("mul_lat", 32'(lat), 32'd2);
    va = {128'd0, 32'd7};
    vb = {128'd0, 32'd6};
    run_op(3'b010, 3'd1, 4'd1);
    check("mul_42", wd1, 32'd42);

    // Logic ops
    va = {32'h0, 32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h1234_5678};
    vb = {32'h0, 32'h0, 32'h0F0F_FFFF, 32'h0FF0_0FF0, 32'hFFFF_0000};
    run_op(3'b011, 3'd3, 4'd2);
    check("and_wd1", wd1, 32'h1234_0000);
    run_op(3'b100, 3'd3, 4'd4);
    check("orr_wd3", wd3, 32'hFFFF_FFFF);
    run_op(3'b101, 3'd3, 4'd5);
    check("eor_wd2", wd2, 32'hF0F0_F0F0);

    // Boundaries: size 0, size 7 clamp, illegal op
    run_op(3'b000, 3'd0, 4'd6);
    check("sz0_lat", 32'(lat), 32'd1);
    check("sz0_vwe", 32'(d_vwe), 32'd0);
    va = {5{32'hFFFF_FFFF}};
    vb = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    run_op(3'b011, 3'd7, 4'd8);
    check("sz7_lat", 32'(lat), 32'd6);
    check("sz7_vsize", 32'(vsize_out), 32'd5);
    check("sz7_wd5", wd5, 32'd5);
    run_op(3'b110, 3'd4, 4'd9);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_err", 32'(d_err), 32'd1);
    check("ill_vwe", 32'(d_vwe), 32'd0);

    // start held high: second op only after WB
    va = {96'd0, 32'd10, 32'd20};
    vb = {96'd0, 32'd1, 32'd2};
    @(posedge clk); #1;
    op = 3'b000; vector_size = 3'd2; wa_in = 4'd10; start = 1'b1;
    @(posedge clk); #1;
    nd = 0; d3 = 1'b0; d7 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (done) begin
        nd++;
        if (c == 3) d3 = 1'b1;
        if (c == 7) d7 = 1'b1;
      end
      if (c == 5) start = 1'b0;
      @(posedge clk); #1;
    end
    check("hold_ndone", 32'(nd), 32'd2);
    check("hold_d3", 32'(d3), 32'd1);
    check("hold_d7", 32'(d7), 32'd1);

    // Operand change mid-EXEC must not leak into results
    va = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vb = {5{32'd100}};
    @(posedge clk); #1;
    op = 3'b000; vector_size = 3'd5; wa_in = 4'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    va = {5{32'hDEAD_BEEF}};
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("late_va_wd2", wd2, 32'd102);
    check("late_va_wd5", wd5, 32'd105);

    // Reset mid-EXEC
    va = {5{32'd9}};
    vb = {5{32'd1}};
    @(posedge clk); #1;
    op = 3'b000; vector_size = 3'd5; wa_in = 4'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_wd1", wd1, 32'd0);
    check("rstx_wa3", 32'(wa3), 32'd0);
    check("rstx_vsize", 32'(vsize_out), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    va = {32'd1, 32'd1, 32'd1, 32'd1, 32'd40};
    vb = {32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
    run_op(3'b000, 3'd1, 4'd13);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_wd1", wd1, 32'd42);
    check("post_rst_vwe", 32'(d_vwe), 32'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
